mul_writeback_ctrl: RTL
=======================

Name: mul_writeback_ctrl

Overview:
Tracks multiply instructions in flight, from issue through the fixed-latency multiply pipeline to register-file writeback. Delays each multiply's metadata (rd index, PC) by exactly the multiplier latency and pairs it with the multiplier's value-only result, producing a qualified writeback. Maintains a per-register pending scoreboard and raises a RAW/WAW stall to the issue stage. Optionally forwards the final-stage result to the issue operands.

Parameters:
MULT_STAGES, 2, multiplier latency in cycles; legal values 2 and 3; must match the multiplier instance.
BYPASS_EN, 1, 1 = forward the final-stage result to issue operands instead of stalling on that match.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
hold_i  in  1  pipeline hold; identical signal to the multiplier's hold
flush_i  in  1  kill all in-flight multiplies not yet written back
issue_valid_i  in  1  instruction presented at issue
issue_mul_i  in  1  presented instruction is MUL/MULH/MULHSU/MULHU
issue_rd_idx_i  in  5  destination register
issue_ra_idx_i  in  5  source A register
issue_rb_idx_i  in  5  source B register
issue_pc_i  in  32  instruction PC
mul_value_i  in  32  multiplier result value
issue_stall_o  out  1  issue must not advance this cycle
byp_ra_valid_o  out  1  forward byp_value_o onto operand A
byp_rb_valid_o  out  1  forward byp_value_o onto operand B
byp_value_o  out  32  equals mul_value_i
wb_valid_o  out  1  register-file write enable
wb_rd_idx_o  out  5  register-file write index
wb_value_o  out  32  register-file write data
wb_pc_o  out  32  PC of the retiring multiply, for trace

Behaviour:
- Reset (async, rst_ni=0): all stage valids = 0, idx/PC = 0, pending mask = 0. Outputs: wb_valid_o=0, wb_rd_idx_o=0, wb_pc_o=0, issue_stall_o=0, byp_*_valid_o=0.
- Accept condition: accept = issue_valid_i & issue_mul_i & ~issue_stall_o & ~hold_i & ~flush_i.
- Pipeline: MULT_STAGES metadata stages S1..SN, each holding {valid, rd, pc}.
  - S1 loads on accept; otherwise S1.valid loads 0 when not held.
  - Sk loads from Sk-1 when ~hold_i.
  - hold_i freezes every stage and the pending mask.
- Latency: a multiply accepted in cycle T gives wb_valid_o=1 in cycle T+MULT_STAGES (with no intervening hold). wb_value_o = mul_value_i, combinational.
- Writeback outputs: wb_valid_o = SN.valid & (SN.rd != 0) & ~hold_i. wb_rd_idx_o and wb_pc_o come from SN.
- Pending mask (32 bits; bit 0 never set):
  - Set bit rd on accept.
  - Clear bit rd when SN retires (SN.valid & ~hold_i).
  - If set and clear hit the same rd in one cycle, set wins.
  - Clears are computed from the pre-set state.
- Flush: on flush_i, all stage valids and the pending mask clear next edge. This has priority over hold_i and over accept. wb_valid_o is still driven for SN in the flush cycle only if ~hold_i.
- Stall: for each used source X in {ra, rb} with X != 0: match_X = pending[X] & ~(BYPASS_EN & SN.valid & SN.rd == X & only SN holds X).
  - issue_stall_o = issue_valid_i & (match_ra | match_rb | (issue_mul_i & pending[rd])).
  - Non-mul instructions also stall on source matches.
  - issue_stall_o is combinational and independent of hold_i.
- Bypass: byp_ra_valid_o = BYPASS_EN & issue_valid_i & SN.valid & SN.rd == ra & ra != 0; byp_rb_valid_o likewise for rb.
- Younger-entry rule: when several stages hold the same rd, bypass is suppressed and stall is asserted. WAW stalls already prevent this case; it is kept as a safety rule.
- Back-to-back: one multiply accepted per cycle. Independent multiplies issue without bubbles.

Decomposition:
- Shared package: MULT_STAGES default, REG_IDX_W=5, XLEN=32, and the stage-entry struct {valid, rd, pc}.
- One natural sub-module: mul_scoreboard (pending mask set/clear/flush plus the match logic), instantiated once.

Test Plan:
- Single MUL, rd=5, issued at cycle 10, mul_value_i=0x0000_0006 → wb_valid_o=1, wb_rd_idx_o=5, wb_value_o=6 at cycle 12 (MULT_STAGES=2); pending[5]=0 afterwards.
- MUL rd=7 at cycle 0, dependent ADD ra=7 at cycle 1 with BYPASS_EN=1 → issue_stall_o=1 at cycle 1; at cycle 2 stall=0, byp_ra_valid_o=1. With BYPASS_EN=0 → stall through cycle 2, released at cycle 3.
- MUL rd=0 → wb_valid_o stays 0; issue_stall_o never asserts for ra=0.
- Hold for 3 cycles mid-flight (issue at 0, hold during cycles 1-3) → writeback moves to cycle 5; wb_valid_o=0 throughout the hold.
- Two in-flight MULs (rd=3, rd=4) with flush_i at cycle 1 → no writeback for either; pending mask=0 at cycle 2; next MUL rd=3 issues without stall.
- rst_ni pulsed low at cycle 1 with a MUL in S1 → all outputs 0 asynchronously; no writeback after reset release.

Source files
------------

// File: rtl/mul_writeback_ctrl_pkg.sv
// mul_writeback_ctrl_pkg: shared widths, default latency and the metadata stage entry
package mul_writeback_ctrl_pkg;
  localparam int MULT_STAGES_DEF = 2;
  localparam int REG_IDX_W       = 5;
  localparam int XLEN            = 32;
  localparam int NREG            = 1 << REG_IDX_W;
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      pc;
  } stage_t;
endpackage

// File: rtl/mul_writeback_ctrl_if.sv
// mul_writeback_ctrl_if: issue, multiplier result, stall/bypass and writeback signals
interface mul_writeback_ctrl_if;
  import mul_writeback_ctrl_pkg::*;
  logic                 hold_i;
  logic                 flush_i;
  logic                 issue_valid_i;
  logic                 issue_mul_i;
  logic [REG_IDX_W-1:0] issue_rd_idx_i;
  logic [REG_IDX_W-1:0] issue_ra_idx_i;
  logic [REG_IDX_W-1:0] issue_rb_idx_i;
  logic [XLEN-1:0]      issue_pc_i;
  logic [XLEN-1:0]      mul_value_i;
  logic                 issue_stall_o;
  logic                 byp_ra_valid_o;
  logic                 byp_rb_valid_o;
  logic [XLEN-1:0]      byp_value_o;
  logic                 wb_valid_o;
  logic [REG_IDX_W-1:0] wb_rd_idx_o;
  logic [XLEN-1:0]      wb_value_o;
  logic [XLEN-1:0]      wb_pc_o;
  modport master (
    output hold_i, flush_i, issue_valid_i, issue_mul_i, issue_rd_idx_i,
           issue_ra_idx_i, issue_rb_idx_i, issue_pc_i, mul_value_i,
    input  issue_stall_o, byp_ra_valid_o, byp_rb_valid_o, byp_value_o,
           wb_valid_o, wb_rd_idx_o, wb_value_o, wb_pc_o
  );
  modport slave (
    input  hold_i, flush_i, issue_valid_i, issue_mul_i, issue_rd_idx_i,
           issue_ra_idx_i, issue_rb_idx_i, issue_pc_i, mul_value_i,
    output issue_stall_o, byp_ra_valid_o, byp_rb_valid_o, byp_value_o,
           wb_valid_o, wb_rd_idx_o, wb_value_o, wb_pc_o
  );
endinterface

// File: rtl/mul_scoreboard.sv
// mul_scoreboard: per-register pending mask for in-flight multiplies and the RAW/WAW stall decision
module mul_scoreboard
  import mul_writeback_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_hold,
  input  logic                 i_flush,
  input  logic                 i_set,
  input  logic [REG_IDX_W-1:0] i_set_idx,
  input  logic                 i_clr,
  input  logic [REG_IDX_W-1:0] i_clr_idx,
  input  logic                 i_issue_valid,
  input  logic                 i_issue_mul,
  input  logic [REG_IDX_W-1:0] i_rd,
  input  logic [REG_IDX_W-1:0] i_ra,
  input  logic [REG_IDX_W-1:0] i_rb,
  input  logic                 i_ra_byp,
  input  logic                 i_rb_byp,
  output logic                 o_stall
);
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;
  logic            w_match_ra;
  logic            w_match_rb;
  assign w_pend_nxt = (r_pend & ~(NREG'(i_clr) << i_clr_idx)) | (NREG'(i_set) << i_set_idx);
  assign w_match_ra = (i_ra != '0) & r_pend[i_ra] & ~i_ra_byp;
  assign w_match_rb = (i_rb != '0) & r_pend[i_rb] & ~i_rb_byp;
  assign o_stall    = i_issue_valid & (w_match_ra | w_match_rb | (i_issue_mul & r_pend[i_rd]));
  // clear-then-set so a same-cycle set wins; flush empties, hold freezes, x0 is never tracked
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_pend <= '0;
    else if (i_flush) r_pend <= '0;
    else if (!i_hold) r_pend <= w_pend_nxt & ~NREG'(1);
  end
endmodule

// File: rtl/mul_writeback_ctrl.sv
// mul_writeback_ctrl: delays multiply metadata to meet the multiplier result and guards issue against hazards
module mul_writeback_ctrl
  import mul_writeback_ctrl_pkg::*;
#(
  parameter int MULT_STAGES = MULT_STAGES_DEF,
  parameter bit BYPASS_EN   = 1'b1
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  mul_writeback_ctrl_if.slave bus
);
  stage_t [MULT_STAGES-1:0] r_stg;
  stage_t                   w_s1;
  stage_t                   w_sn;
  logic                     w_accept;
  logic                     w_retire;
  logic                     w_ra_byp;
  logic                     w_rb_byp;
  logic [MULT_STAGES-2:0]   w_ra_yng;
  logic [MULT_STAGES-2:0]   w_rb_yng;
  assign w_sn     = r_stg[MULT_STAGES-1];
  assign w_accept = bus.issue_valid_i & bus.issue_mul_i & ~bus.issue_stall_o & ~bus.hold_i & ~bus.flush_i;
  assign w_retire = w_sn.valid & ~bus.hold_i;
  assign w_s1     = '{valid: w_accept, rd: bus.issue_rd_idx_i, pc: bus.issue_pc_i};
  for (genvar g = 0; g < MULT_STAGES-1; g++) begin : g_yng
    assign w_ra_yng[g] = r_stg[g].valid & (r_stg[g].rd == bus.issue_ra_idx_i);
    assign w_rb_yng[g] = r_stg[g].valid & (r_stg[g].rd == bus.issue_rb_idx_i);
  end
  assign w_ra_byp = BYPASS_EN & w_sn.valid & (w_sn.rd == bus.issue_ra_idx_i) & (bus.issue_ra_idx_i != '0) & ~|w_ra_yng;
  assign w_rb_byp = BYPASS_EN & w_sn.valid & (w_sn.rd == bus.issue_rb_idx_i) & (bus.issue_rb_idx_i != '0) & ~|w_rb_yng;
  assign bus.byp_ra_valid_o = bus.issue_valid_i & w_ra_byp;
  assign bus.byp_rb_valid_o = bus.issue_valid_i & w_rb_byp;
  assign bus.byp_value_o    = bus.mul_value_i;
  assign bus.wb_valid_o     = w_sn.valid & (w_sn.rd != '0) & ~bus.hold_i;
  assign bus.wb_rd_idx_o    = w_sn.rd;
  assign bus.wb_pc_o        = w_sn.pc;
  assign bus.wb_value_o     = bus.mul_value_i;
  // metadata shift register: flush kills every entry, hold freezes, S1 captures the accepted multiply
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_stg <= '0;
    else if (bus.flush_i) begin
      for (int k = 0; k < MULT_STAGES; k++) r_stg[k].valid <= 1'b0;
    end
    else if (!bus.hold_i) r_stg <= {r_stg[MULT_STAGES-2:0], w_s1};
  end
  mul_scoreboard u_sb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .i_hold        (bus.hold_i),
    .i_flush       (bus.flush_i),
    .i_set         (w_accept),
    .i_set_idx     (bus.issue_rd_idx_i),
    .i_clr         (w_retire),
    .i_clr_idx     (w_sn.rd),
    .i_issue_valid (bus.issue_valid_i),
    .i_issue_mul   (bus.issue_mul_i),
    .i_rd          (bus.issue_rd_idx_i),
    .i_ra          (bus.issue_ra_idx_i),
    .i_rb          (bus.issue_rb_idx_i),
    .i_ra_byp      (w_ra_byp),
    .i_rb_byp      (w_rb_byp),
    .o_stall       (bus.issue_stall_o)
  );
endmodule
